// File: rtl/izh_param_loader.sv
// -----------------------------------------------------------------------------
// izh_param_loader
//
// Configuration front end for the Izhikevich neuron core. Accepts a byte-serial
// parameter frame (SYNC, A, B, C, D, CHK with CHK = A^B^C^D) or a built-in
// preset, and presents the committed parameter set to the neuron. Incoming
// bytes land in shadow registers; the visible set changes only on a good
// checksum or a preset load, so the neuron never sees a partial update.
//
// Ports
//   clk           in   1  clock, all logic on rising edge
//   reset         in   1  synchronous, active-high
//   data_in       in   8  serial frame byte
//   data_valid    in   1  data_in carries a byte this cycle
//   preset_sel    in   2  preset index: 0=RS 1=IB 2=CH 3=FS
//   preset_load   in   1  one-cycle request to load preset_sel (IDLE only)
//   param_a..d    out  8  committed parameter set
//   params_ready  out  1  a valid set has been committed since reset
//   load_busy     out  1  frame reception in progress
//   frame_ok      out  1  one-cycle pulse: frame or preset committed
//   frame_error   out  1  one-cycle pulse: checksum mismatch or timeout
// -----------------------------------------------------------------------------
module izh_param_loader #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 255      // 1..65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic [1:0] preset_sel,
    input  logic       preset_load,
    output logic [7:0] param_a,
    output logic [7:0] param_b,
    output logic [7:0] param_c,
    output logic [7:0] param_d,
    output logic       params_ready,
    output logic       load_busy,
    output logic       frame_ok,
    output logic       frame_error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_A,
        ST_RX_B,
        ST_RX_C,
        ST_RX_D,
        ST_RX_CHK
    } state_t;

    // The idle-cycle counter fires when it is about to reach TIMEOUT_CYC, so
    // the error appears at the edge that completes the TIMEOUT_CYC-th idle cycle.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_timeout_cnt;
    logic [15:0] w_timeout_cnt_next;

    logic [7:0]  r_shadow_a;
    logic [7:0]  r_shadow_b;
    logic [7:0]  r_shadow_c;
    logic [7:0]  r_shadow_d;

    logic [7:0]  r_param_a;
    logic [7:0]  r_param_b;
    logic [7:0]  r_param_c;
    logic [7:0]  r_param_d;
    logic        r_params_ready;
    logic        r_load_busy;
    logic        r_frame_ok;
    logic        r_frame_error;

    logic        w_frame_commit;
    logic        w_frame_fail;
    logic        w_preset_commit;
    logic [7:0]  w_checksum;
    logic [7:0]  w_preset_a;
    logic [7:0]  w_preset_b;
    logic [7:0]  w_preset_c;
    logic [7:0]  w_preset_d;

    assign w_checksum = r_shadow_a ^ r_shadow_b ^ r_shadow_c ^ r_shadow_d;

    // Preset table: RS, IB, CH, FS in the neuron core's byte encoding.
    always_comb begin
        w_preset_a = 8'd2;
        w_preset_b = 8'd20;
        w_preset_c = 8'd133;
        w_preset_d = 8'd128;
        case (preset_sel)
            2'd1: begin w_preset_c = 8'd143; w_preset_d = 8'd64; end
            2'd2: begin w_preset_c = 8'd148; w_preset_d = 8'd32; end
            2'd3: begin w_preset_a = 8'd10;  w_preset_d = 8'd32; end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: state and all other registers use non-blocking assignments so
        // every flop samples pre-edge values, independent of statement order.
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and commit decisions.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        w_next_state       = r_state;
        w_timeout_cnt_next = 16'd0;
        w_frame_commit     = 1'b0;
        w_frame_fail       = 1'b0;
        w_preset_commit    = 1'b0;

        if (r_state == ST_IDLE) begin
            // A preset request wins over any byte arriving in the same cycle.
            if (preset_load) begin
                w_preset_commit = 1'b1;
            end else if (data_valid && (data_in == SYNC_BYTE)) begin
                w_next_state = ST_RX_A;
            end
        end else if (data_valid) begin
            // Inside a frame every byte is data, including SYNC_BYTE.
            case (r_state)
                ST_RX_A: w_next_state = ST_RX_B;
                ST_RX_B: w_next_state = ST_RX_C;
                ST_RX_C: w_next_state = ST_RX_D;
                ST_RX_D: w_next_state = ST_RX_CHK;
                default: begin
                    w_next_state   = ST_IDLE;
                    w_frame_commit = (data_in == w_checksum);
                    w_frame_fail   = (data_in != w_checksum);
                end
            endcase
        end else if (r_timeout_cnt == TIMEOUT_LAST) begin
            w_next_state = ST_IDLE;
            w_frame_fail = 1'b1;
        end else begin
            w_timeout_cnt_next = r_timeout_cnt + 16'd1;
        end
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout_cnt  <= 16'd0;
            r_shadow_a     <= 8'd0;
            r_shadow_b     <= 8'd0;
            r_shadow_c     <= 8'd0;
            r_shadow_d     <= 8'd0;
            r_param_a      <= 8'd0;
            r_param_b      <= 8'd0;
            r_param_c      <= 8'd0;
            r_param_d      <= 8'd0;
            r_params_ready <= 1'b0;
            r_load_busy    <= 1'b0;
            r_frame_ok     <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_timeout_cnt <= w_timeout_cnt_next;
            r_load_busy   <= (w_next_state != ST_IDLE);
            r_frame_ok    <= w_frame_commit | w_preset_commit;
            r_frame_error <= w_frame_fail;

            if (data_valid) begin
                case (r_state)
                    ST_RX_A: r_shadow_a <= data_in;
                    ST_RX_B: r_shadow_b <= data_in;
                    ST_RX_C: r_shadow_c <= data_in;
                    ST_RX_D: r_shadow_d <= data_in;
                    default: ;
                endcase
            end

            if (w_frame_commit) begin
                r_param_a      <= r_shadow_a;
                r_param_b      <= r_shadow_b;
                r_param_c      <= r_shadow_c;
                r_param_d      <= r_shadow_d;
                r_params_ready <= 1'b1;
            end else if (w_preset_commit) begin
                r_param_a      <= w_preset_a;
                r_param_b      <= w_preset_b;
                r_param_c      <= w_preset_c;
                r_param_d      <= w_preset_d;
                r_params_ready <= 1'b1;
            end
        end
    end

    assign param_a      = r_param_a;
    assign param_b      = r_param_b;
    assign param_c      = r_param_c;
    assign param_d      = r_param_d;
    assign params_ready = r_params_ready;
    assign load_busy    = r_load_busy;
    assign frame_ok     = r_frame_ok;
    assign frame_error  = r_frame_error;

endmodule

// File: tb/tb_izh_param_loader.sv
// -----------------------------------------------------------------------------
// tb_izh_param_loader
//
// Directed bench for izh_param_loader: frame commit, bad checksum, timeout,
// presets (including priority and RX-state blocking), SYNC bytes as data and
// reset mid-frame. Inputs change 1 time unit after the rising edge; outputs
// are sampled at the same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_izh_param_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic [1:0] preset_sel;
    logic       preset_load;
    logic [7:0] param_a;
    logic [7:0] param_b;
    logic [7:0] param_c;
    logic [7:0] param_d;
    logic       params_ready;
    logic       load_busy;
    logic       frame_ok;
    logic       frame_error;

    int checks = 0;
    int errors = 0;

    izh_param_loader #(
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (255)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .preset_sel   (preset_sel),
        .preset_load  (preset_load),
        .param_a      (param_a),
        .param_b      (param_b),
        .param_c      (param_c),
        .param_d      (param_d),
        .params_ready (params_ready),
        .load_busy    (load_busy),
        .frame_ok     (frame_ok),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_params(input string tag, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d);
        check({tag, ".a"}, {24'd0, param_a}, {24'd0, a});
        check({tag, ".b"}, {24'd0, param_b}, {24'd0, b});
        check({tag, ".c"}, {24'd0, param_c}, {24'd0, c});
        check({tag, ".d"}, {24'd0, param_d}, {24'd0, d});
    endtask

    // Status vector: {params_ready, load_busy, frame_ok, frame_error}.
    function automatic logic [31:0] status();
        return {28'd0, params_ready, load_busy, frame_ok, frame_error};
    endfunction

    // Drive one valid byte for one cycle; data_valid stays high for bursts.
    task automatic send(input logic [7:0] b);
        data_in    = b;
        data_valid = 1'b1;
        step();
    endtask

    task automatic idle();
        data_valid = 1'b0;
        data_in    = 8'h00;
    endtask

    initial begin
        reset       = 1'b1;
        data_in     = 8'h00;
        data_valid  = 1'b0;
        preset_sel  = 2'd0;
        preset_load = 1'b0;
        step();
        step();

        // Reset state.
        check_params("reset", 8'h00, 8'h00, 8'h00, 8'h00);
        check("reset.status", status(), 32'h0);
        reset = 1'b0;
        step();

        // 1. Valid frame A5,02,14,85,80,13.
        send(8'hA5);
        check("t1.busy_after_sync", status(), 32'b0100);
        send(8'h02);
        send(8'h14);
        send(8'h85);
        send(8'h80);
        check("t1.busy_before_chk", status(), 32'b0100);
        check_params("t1.held_before_chk", 8'h00, 8'h00, 8'h00, 8'h00);
        send(8'h13);
        idle();
        check_params("t1.commit", 8'h02, 8'h14, 8'h85, 8'h80);
        check("t1.status_commit", status(), 32'b1010);
        step();
        check("t1.status_after", status(), 32'b1000);

        // 2. Bad checksum: A5,0A,14,85,20,00 (correct would be BB).
        send(8'hA5);
        send(8'h0A);
        send(8'h14);
        send(8'h85);
        send(8'h20);
        send(8'h00);
        idle();
        check("t2.status_err", status(), 32'b1001);
        check_params("t2.hold", 8'h02, 8'h14, 8'h85, 8'h80);
        step();
        check("t2.status_after", status(), 32'b1000);

        // 3. Timeout: A5,01 then 255 idle cycles.
        send(8'hA5);
        send(8'h01);
        idle();
        for (int i = 0; i < 254; i++) step();
        check("t3.before_timeout", status(), 32'b1100);
        step();
        check("t3.timeout", status(), 32'b1001);
        check_params("t3.hold", 8'h02, 8'h14, 8'h85, 8'h80);
        step();
        check("t3.after_timeout", status(), 32'b1000);
        // Next valid frame: 0A,14,8F,40 -> CHK D1.
        send(8'hA5);
        send(8'h0A);
        send(8'h14);
        send(8'h8F);
        send(8'h40);
        send(8'hD1);
        idle();
        check("t3.refill_status", status(), 32'b1010);
        check_params("t3.refill", 8'h0A, 8'h14, 8'h8F, 8'h40);
        step();

        // 4. Preset CH in IDLE.
        preset_sel  = 2'd2;
        preset_load = 1'b1;
        step();
        preset_load = 1'b0;
        check("t4.preset_status", status(), 32'b1010);
        check_params("t4.preset_ch", 8'h02, 8'h14, 8'h94, 8'h20);
        step();
        check("t4.preset_pulse_end", status(), 32'b1000);
        // Preset request while in RX_B is ignored.
        send(8'hA5);
        send(8'h11);
        idle();
        preset_sel  = 2'd3;
        preset_load = 1'b1;
        step();
        preset_load = 1'b0;
        check("t4.rx_preset_status", status(), 32'b1100);
        check_params("t4.rx_preset_ignored", 8'h02, 8'h14, 8'h94, 8'h20);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        send(8'h44);
        idle();
        check("t4.frame_after_status", status(), 32'b1010);
        check_params("t4.frame_after", 8'h11, 8'h22, 8'h33, 8'h44);
        step();
        // Preset and SYNC together in IDLE: preset RS wins, SYNC dropped.
        preset_sel  = 2'd0;
        preset_load = 1'b1;
        data_in     = 8'hA5;
        data_valid  = 1'b1;
        step();
        preset_load = 1'b0;
        idle();
        check("t4.prio_status", status(), 32'b1010);
        check_params("t4.prio_rs", 8'h02, 8'h14, 8'h85, 8'h80);
        send(8'h01);
        idle();
        check("t4.sync_dropped", status(), 32'b1000);
        // Preset FS.
        preset_sel  = 2'd3;
        preset_load = 1'b1;
        step();
        preset_load = 1'b0;
        check_params("t4.preset_fs", 8'h0A, 8'h14, 8'h85, 8'h20);
        // Preset IB.
        preset_sel  = 2'd1;
        preset_load = 1'b1;
        step();
        preset_load = 1'b0;
        check_params("t4.preset_ib", 8'h02, 8'h14, 8'h8F, 8'h40);
        step();

        // 5. 00,A5,A5,01,02,03,A5: SYNC value used as data.
        send(8'h00);
        check("t5.leading_ignored", status(), 32'b1000);
        send(8'hA5);
        send(8'hA5);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'hA5);
        idle();
        check("t5.status", status(), 32'b1010);
        check_params("t5.commit", 8'hA5, 8'h01, 8'h02, 8'h03);
        step();

        // 6. Reset during RX_C.
        send(8'hA5);
        send(8'h01);
        send(8'h02);
        idle();
        check("t6.busy_in_rx_c", status(), 32'b1100);
        reset = 1'b1;
        step();
        check_params("t6.reset", 8'h00, 8'h00, 8'h00, 8'h00);
        check("t6.reset_status", status(), 32'h0);
        reset = 1'b0;
        // Partial frame is gone: a lone byte does not resume it.
        send(8'h03);
        idle();
        check("t6.partial_lost", status(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
